// File: rtl/pipe_render_engine.sv
// pipe_render_engine: draws NUM_PIPES top/bottom pipe pairs from a shared
// cap/shaft sprite ROM. Pipe geometry is shadow-latched on frame_start, so
// game-logic updates never tear a frame. Counters reach pipe_pixel/pipe_flag
// through three register stages.
// Optional feature macro: PIPE_COLLISION_EN (sticky bird-vs-pipe collision).
module pipe_render_engine #(
    parameter int NUM_PIPES = 3,
    parameter int CW        = 11,
    parameter int PIPE_W    = 50,
    parameter int V_ACTIVE  = 480,
    parameter int PIX_W     = 8,
    localparam int IW       = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CW-1:0]           hcounter,
    input  logic [CW-1:0]           vcounter,
    input  logic                    frame_start,
    input  logic [NUM_PIPES-1:0]    pipe_enable,
    input  logic [NUM_PIPES*CW-1:0] pipe_position,
    input  logic [NUM_PIPES*CW-1:0] pipe_center,
    input  logic [NUM_PIPES*CW-1:0] pipe_gap,
    output logic [7:0]              rom_addr,
    input  logic [3:0]              rom_data,
    output logic [PIX_W-1:0]        pipe_pixel,
    output logic                    pipe_flag,
    output logic [IW-1:0]           pipe_idx,
    input  logic                    bird_flag,
    output logic                    collision,
    input  logic                    collision_clr
);

    // Geometry is signed; two bits of headroom over the counters keep
    // x0 + PIPE_W and gt + gap free of any wrap for full-range inputs.
    localparam int SW   = CW + 2;
    localparam int COLW = (PIPE_W > 1) ? $clog2(PIPE_W) : 1;

    localparam logic signed [SW-1:0] HALF_W_S = SW'(PIPE_W / 2);
    localparam logic signed [SW-1:0] FULL_W_S = SW'(PIPE_W);
    localparam logic signed [SW-1:0] VA_S     = SW'(V_ACTIVE);
    localparam logic signed [SW-1:0] ONE_S    = SW'(1);
    localparam logic signed [SW-1:0] D22_S    = SW'(22);
    localparam logic signed [SW-1:0] D23_S    = SW'(23);
    localparam logic signed [SW-1:0] D24_S    = SW'(24);
    localparam logic signed [SW-1:0] D25_S    = SW'(25);

    localparam logic [7:0] MISS_ADDR = 8'd101;
    localparam logic [7:0] IDLE_PIX  = 8'h49;

    // Sprite palette index to RRRGGGBB colour; 0, E and F show background.
    function automatic logic [7:0] palette(input logic [3:0] code);
        logic [7:0] pix;
        case (code)
            4'h1:    pix = 8'h69;
            4'h2:    pix = 8'h10;
            4'h3:    pix = 8'h78;
            4'h4:    pix = 8'h74;
            4'h5:    pix = 8'h54;
            4'h6:    pix = 8'h30;
            4'h7:    pix = 8'hDC;
            4'h8:    pix = 8'hBC;
            4'h9:    pix = 8'hB8;
            4'hA:    pix = 8'h98;
            4'hB:    pix = 8'h50;
            4'hC:    pix = 8'h94;
            4'hD:    pix = 8'h2C;
            default: pix = IDLE_PIX;
        endcase
        return pix;
    endfunction

    logic signed [SW-1:0] h_s;
    logic signed [SW-1:0] v_s;

    assign h_s = SW'(hcounter);
    assign v_s = SW'(vcounter);

    logic [NUM_PIPES-1:0] pipe_hit;
    logic [2:0]           pipe_cls [NUM_PIPES];
    logic [COLW-1:0]      pipe_col [NUM_PIPES];

    for (genvar gi = 0; gi < NUM_PIPES; gi++) begin : g_pipe
        logic [CW-1:0]        pos_reg;
        logic [CW-1:0]        center_reg;
        logic [CW-1:0]        gap_reg;
        logic                 en_reg;
        logic signed [SW-1:0] pos_s;
        logic signed [SW-1:0] center_s;
        logic signed [SW-1:0] gap_s;
        logic signed [SW-1:0] x0;
        logic signed [SW-1:0] gt;
        logic signed [SW-1:0] gb;
        logic signed [SW-1:0] d_bot;
        logic signed [SW-1:0] d_top;
        logic                 in_col;
        logic                 in_bot;
        logic                 in_top;
        logic [2:0]           cls;

        // Shadow copy of this pipe's geometry, reloaded only at frame_start.
        always_ff @(posedge clk) begin
            if (rst) begin
                pos_reg    <= '0;
                center_reg <= '0;
                gap_reg    <= '0;
                en_reg     <= 1'b0;
            end else if (frame_start) begin
                pos_reg    <= pipe_position[gi*CW +: CW];
                center_reg <= pipe_center[gi*CW +: CW];
                gap_reg    <= pipe_gap[gi*CW +: CW];
                en_reg     <= pipe_enable[gi];
            end
        end

        assign pos_s    = SW'(pos_reg);
        assign center_s = SW'(center_reg);
        assign gap_s    = SW'(gap_reg);

        // Left edge may go negative so pipes clip cleanly at column 0.
        assign x0 = pos_s - HALF_W_S;
        assign gt = center_s - (gap_s >>> 1);
        assign gb = gt + gap_s;

        assign in_col = (h_s >= x0) && (h_s < x0 + FULL_W_S);
        // A gap taller than the screen suppresses the bottom pipe entirely.
        assign in_bot = (v_s >= gb) && (v_s < VA_S) && (gap_s < VA_S);
        assign in_top = (v_s <= gt) && (v_s >= ONE_S);

        assign d_bot = v_s - gb;
        assign d_top = gt - v_s;

        // Sprite row class from the distance into the pipe, measured from the gap.
        always_comb begin
            cls = 3'd4;
            if (in_bot) begin
                if ((d_bot <= ONE_S) || (d_bot == D23_S)) begin
                    cls = 3'd0;
                end else if (d_bot <= D22_S) begin
                    cls = 3'd1;
                end else if (d_bot == D24_S) begin
                    cls = 3'd2;
                end else if (d_bot == D25_S) begin
                    cls = 3'd3;
                end else begin
                    cls = 3'd4;
                end
            end else begin
                if ((d_top <= ONE_S) || (d_top == D23_S)) begin
                    cls = 3'd0;
                end else if (d_top <= D22_S) begin
                    cls = 3'd1;
                end else begin
                    cls = 3'd4;
                end
            end
        end

        assign pipe_hit[gi] = en_reg && in_col && (in_bot || in_top);
        assign pipe_cls[gi] = cls;
        assign pipe_col[gi] = COLW'(h_s - x0);
    end

    logic            s1_hit_next;
    logic [2:0]      s1_cls_next;
    logic [COLW-1:0] s1_col_next;
    logic [IW-1:0]   s1_idx_next;

    // Priority pick: scanning downward lets the lowest-index hit overwrite.
    always_comb begin
        s1_hit_next = 1'b0;
        s1_cls_next = '0;
        s1_col_next = '0;
        s1_idx_next = '0;
        for (int i = NUM_PIPES - 1; i >= 0; i--) begin
            if (pipe_hit[i]) begin
                s1_hit_next = 1'b1;
                s1_cls_next = pipe_cls[i];
                s1_col_next = pipe_col[i];
                s1_idx_next = IW'(i);
            end
        end
    end

    logic            s1_hit_reg;
    logic [2:0]      s1_cls_reg;
    logic [COLW-1:0] s1_col_reg;
    logic [IW-1:0]   s1_idx_reg;

    // Stage 1: register the winning pipe's hit, row class, column and index.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_hit_reg <= 1'b0;
            s1_cls_reg <= '0;
            s1_col_reg <= '0;
            s1_idx_reg <= '0;
        end else begin
            s1_hit_reg <= s1_hit_next;
            s1_cls_reg <= s1_cls_next;
            s1_col_reg <= s1_col_next;
            s1_idx_reg <= s1_idx_next;
        end
    end

    logic [7:0]    s2_addr_next;
    logic [7:0]    rom_addr_reg;
    logic          s2_hit_reg;
    logic [IW-1:0] s2_idx_reg;

    // ROM row layout is class-major, PIPE_W entries per class row.
    always_comb begin
        s2_addr_next = MISS_ADDR;
        if (s1_hit_reg) begin
            s2_addr_next = 8'(s1_cls_reg) * 8'(PIPE_W) + 8'(s1_col_reg);
        end
    end

    // Stage 2: registered ROM address plus hit/index carried alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr_reg <= MISS_ADDR;
            s2_hit_reg   <= 1'b0;
            s2_idx_reg   <= '0;
        end else begin
            rom_addr_reg <= s2_addr_next;
            s2_hit_reg   <= s1_hit_reg;
            s2_idx_reg   <= s1_idx_reg;
        end
    end

    assign rom_addr = rom_addr_reg;

    logic [PIX_W-1:0] pixel_reg;
    logic             flag_reg;
    logic [IW-1:0]    idx_reg;

    // Stage 3: palette lookup; palette index 0 is transparent.
    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_reg <= PIX_W'(IDLE_PIX);
            flag_reg  <= 1'b0;
            idx_reg   <= '0;
        end else begin
            pixel_reg <= PIX_W'(palette(rom_data));
            flag_reg  <= s2_hit_reg && (rom_data != 4'd0);
            idx_reg   <= s2_idx_reg;
        end
    end

    assign pipe_pixel = pixel_reg;
    assign pipe_flag  = flag_reg;
    assign pipe_idx   = idx_reg;

`ifdef PIPE_COLLISION_EN
    logic bird_d1_reg;
    logic bird_d2_reg;
    logic bird_d3_reg;
    logic collision_reg;

    // Delay bird_flag by the pipeline depth so it lines up with pipe_flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            bird_d1_reg <= 1'b0;
            bird_d2_reg <= 1'b0;
            bird_d3_reg <= 1'b0;
        end else begin
            bird_d1_reg <= bird_flag;
            bird_d2_reg <= bird_d1_reg;
            bird_d3_reg <= bird_d2_reg;
        end
    end

    // Sticky collision; a new overlap beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            collision_reg <= 1'b0;
        end else if (flag_reg && bird_d3_reg) begin
            collision_reg <= 1'b1;
        end else if (collision_clr) begin
            collision_reg <= 1'b0;
        end
    end

    assign collision = collision_reg;
`else
    logic collision_unused;

    assign collision_unused = bird_flag ^ collision_clr;
    assign collision        = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_render_engine.sv
// tb_pipe_render_engine: directed plus randomized pixel stream against a
// behavioural pipe model; sprite ROM is a random table read from rom_addr.
module tb_pipe_render_engine;

    localparam int NP   = 3;
    localparam int CW   = 11;
    localparam int PW   = 50;
    localparam int VA   = 480;
    localparam int IW   = 2;
    localparam int MAXS = 1024;

    logic             clk = 1'b0;
    logic             rst;
    logic [CW-1:0]    hcounter;
    logic [CW-1:0]    vcounter;
    logic             frame_start;
    logic [NP-1:0]    pipe_enable;
    logic [NP*CW-1:0] pipe_position;
    logic [NP*CW-1:0] pipe_center;
    logic [NP*CW-1:0] pipe_gap;
    logic [7:0]       rom_addr;
    logic [3:0]       rom_data;
    logic [7:0]       pipe_pixel;
    logic             pipe_flag;
    logic [IW-1:0]    pipe_idx;
    logic             bird_flag;
    logic             collision;
    logic             collision_clr;

    int checks = 0;
    int errors = 0;

    logic [3:0] rom [256];

    // Model of a ROM whose address register is rom_addr itself.
    assign rom_data = rom[rom_addr];

    // Pixel clock.
    always #5 clk = ~clk;

    pipe_render_engine dut (
        .clk           (clk),
        .rst           (rst),
        .hcounter      (hcounter),
        .vcounter      (vcounter),
        .frame_start   (frame_start),
        .pipe_enable   (pipe_enable),
        .pipe_position (pipe_position),
        .pipe_center   (pipe_center),
        .pipe_gap      (pipe_gap),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .pipe_pixel    (pipe_pixel),
        .pipe_flag     (pipe_flag),
        .pipe_idx      (pipe_idx),
        .bird_flag     (bird_flag),
        .collision     (collision),
        .collision_clr (collision_clr)
    );

    // Reference shadow geometry and per-step expectations.
    bit m_en  [NP];
    int m_pos [NP];
    int m_cen [NP];
    int m_gap [NP];
    bit m_coll = 1'b0;

    bit e_hit  [MAXS];
    int e_idx  [MAXS];
    int e_addr [MAXS];
    bit e_rst  [MAXS];
    bit e_bird [MAXS];
    int n = 0;

    function automatic logic [7:0] pal(input logic [3:0] c);
        case (c)
            4'h1: return 8'h69;
            4'h2: return 8'h10;
            4'h3: return 8'h78;
            4'h4: return 8'h74;
            4'h5: return 8'h54;
            4'h6: return 8'h30;
            4'h7: return 8'hDC;
            4'h8: return 8'hBC;
            4'h9: return 8'hB8;
            4'hA: return 8'h98;
            4'hB: return 8'h50;
            4'hC: return 8'h94;
            4'hD: return 8'h2C;
            default: return 8'h49;
        endcase
    endfunction

    function automatic int bot_class(input int d);
        if (d == 0 || d == 1 || d == 23) return 0;
        if (d >= 2 && d <= 22) return 1;
        if (d == 24) return 2;
        if (d == 25) return 3;
        return 4;
    endfunction

    function automatic int top_class(input int d);
        if (d == 0 || d == 1 || d == 23) return 0;
        if (d >= 2 && d <= 22) return 1;
        return 4;
    endfunction

    function automatic bit exp_flag(input int j);
        return !e_rst[j] && e_hit[j] && (rom[e_addr[j]] != 4'd0);
    endfunction

    task automatic ref_pixel(input int h, input int v, output bit hit, output int idx, output int addr);
        int x0, gt, gb;
        hit = 1'b0;
        idx = 0;
        addr = 101;
        for (int i = 0; i < NP; i++) begin
            if (hit || !m_en[i]) continue;
            x0 = m_pos[i] - PW / 2;
            gt = m_cen[i] - m_gap[i] / 2;
            gb = gt + m_gap[i];
            if (h < x0 || h >= x0 + PW) continue;
            if (v >= gb && v < VA && m_gap[i] < VA) begin
                hit = 1'b1; idx = i; addr = bot_class(v - gb) * PW + (h - x0);
            end else if (v <= gt && v >= 1) begin
                hit = 1'b1; idx = i; addr = top_class(gt - v) * PW + (h - x0);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_geom(input int i, input int pos, input int cen, input int gap);
        pipe_position[i*CW +: CW] = CW'(pos);
        pipe_center[i*CW +: CW]   = CW'(cen);
        pipe_gap[i*CW +: CW]      = CW'(gap);
    endtask

    // One pixel clock: drive counters/controls, update the model, check outputs.
    task automatic step(input int h, input int v, input bit fs, input bit b, input bit clr, input bit r);
        bit hit;
        int idx, addr;
        bit coll_hit;
        @(negedge clk);
        hcounter      = CW'(h);
        vcounter      = CW'(v);
        frame_start   = fs;
        bird_flag     = b;
        collision_clr = clr;
        rst           = r;
        ref_pixel(h, v, hit, idx, addr);
        e_hit[n]  = hit;
        e_idx[n]  = idx;
        e_addr[n] = addr;
        e_rst[n]  = 1'b0;
        e_bird[n] = b;
        coll_hit = (n >= 3) ? (exp_flag(n - 3) && e_bird[n - 3]) : 1'b0;
        if (r) begin
            e_hit[n] = 1'b0; e_addr[n] = 101;
            if (n >= 1) begin e_hit[n - 1] = 1'b0; e_addr[n - 1] = 101; end
            if (n >= 2) e_rst[n - 2] = 1'b1;
            m_coll = 1'b0;
            for (int i = 0; i < NP; i++) begin
                m_en[i] = 1'b0; m_pos[i] = 0; m_cen[i] = 0; m_gap[i] = 0;
            end
        end else begin
            if (coll_hit) m_coll = 1'b1;
            else if (clr) m_coll = 1'b0;
            if (fs) begin
                for (int i = 0; i < NP; i++) begin
                    m_en[i]  = pipe_enable[i];
                    m_pos[i] = int'(pipe_position[i*CW +: CW]);
                    m_cen[i] = int'(pipe_center[i*CW +: CW]);
                    m_gap[i] = int'(pipe_gap[i*CW +: CW]);
                end
            end
        end
        @(posedge clk);
        #1;
        if (n >= 1) chk("rom_addr", rom_addr, e_addr[n - 1]);
        if (n >= 2) begin
            if (e_rst[n - 2]) begin
                chk("pixel_rst", pipe_pixel, 8'h49);
                chk("idx_rst", pipe_idx, 0);
            end else begin
                chk("pixel", pipe_pixel, pal(rom[e_addr[n - 2]]));
                if (exp_flag(n - 2)) chk("idx", pipe_idx, e_idx[n - 2]);
            end
            chk("flag", pipe_flag, exp_flag(n - 2));
        end
`ifdef PIPE_COLLISION_EN
        chk("collision", collision, m_coll);
`else
        chk("collision_off", collision, 0);
`endif
        $display("step %0d h=%0d v=%0d fs=%0b rst=%0b addr=%0d pix=%02h flag=%0b idx=%0d coll=%0b",
                 n, h, v, fs, r, rom_addr, pipe_pixel, pipe_flag, pipe_idx, collision);
        n++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 4'($urandom_range(0, 15));
        rom[0]   = 4'h3;
        rom[50]  = 4'h0;
        rom[205] = 4'h5;
        rom[65]  = 4'h9;
        rom[75]  = 4'h9;
        rst = 1'b1; frame_start = 1'b0; bird_flag = 1'b0; collision_clr = 1'b0;
        hcounter = '0; vcounter = '0;
        pipe_enable = '0; pipe_position = '0; pipe_center = '0; pipe_gap = '0;

        // Reset and an empty frame.
        repeat (3) step(0, 0, 0, 0, 0, 1);
        step(10, 10, 0, 0, 0, 0);

        // Pipe 0: x0=75, gt=190, gb=290; walk the row classes.
        set_geom(0, 100, 240, 100);
        pipe_enable = 3'b001;
        step(0, 0, 1, 0, 0, 0);
        step(75, 290, 0, 0, 0, 0);
        step(75, 295, 0, 0, 0, 0);
        chk("addr_cap_row0", rom_addr, 0);
        step(80, 314, 0, 0, 0, 0);
        chk("addr_shaft", rom_addr, 50);
        step(80, 315, 0, 0, 0, 0);
        chk("addr_class2", rom_addr, 105);
        step(80, 316, 0, 0, 0, 0);
        chk("addr_class3", rom_addr, 155);
        step(80, 400, 0, 0, 0, 0);
        chk("addr_class4_bot", rom_addr, 205);
        step(80, 150, 0, 1, 0, 0);
        chk("addr_class4_bot2", rom_addr, 205);
        step(125, 150, 0, 0, 0, 0);
        chk("addr_class4_top", rom_addr, 205);
        step(0, 0, 0, 0, 0, 0);
        chk("addr_right_miss", rom_addr, 101);
        step(0, 0, 0, 0, 0, 0);
`ifdef PIPE_COLLISION_EN
        chk("coll_set", collision, 1);
`endif
        step(0, 0, 0, 0, 1, 0);
`ifdef PIPE_COLLISION_EN
        chk("coll_clear", collision, 0);
`endif

        // Geometry change without frame_start must not show; with it, it does.
        set_geom(0, 300, 240, 100);
        step(80, 300, 0, 0, 0, 0);
        step(80, 300, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(280, 300, 0, 0, 0, 0);
        step(80, 300, 0, 0, 0, 0);

        // Left-edge clipping: x0 = -15.
        set_geom(0, 10, 240, 100);
        step(0, 0, 1, 0, 0, 0);
        step(0, 300, 0, 0, 0, 0);
        step(35, 300, 0, 0, 0, 0);
        chk("addr_clip_col15", rom_addr, 65);
        step(34, 300, 0, 0, 0, 0);
        chk("addr_clip_miss", rom_addr, 101);

        // Overlap priority.
        set_geom(0, 100, 240, 100);
        set_geom(1, 110, 240, 100);
        pipe_enable = 3'b011;
        step(0, 0, 1, 0, 0, 0);
        step(100, 300, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("idx_overlap0", pipe_idx, 0);
        pipe_enable = 3'b010;
        step(0, 0, 1, 0, 0, 0);
        step(100, 300, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("idx_overlap1", pipe_idx, 1);

        // Reset mid-frame, with frame_start also high: reset wins.
        step(100, 300, 1, 0, 0, 1);
        chk("pixel_after_rst", pipe_pixel, 8'h49);
        step(100, 300, 0, 0, 0, 0);
        step(100, 300, 0, 0, 0, 0);

        // Randomized frames.
        for (int k = 0; k < 500; k++) begin
            bit fs;
            int p, h, v, gt, gb;
            fs = 1'b0;
            if (k % 50 == 0) begin
                for (int i = 0; i < NP; i++)
                    set_geom(i, int'($urandom_range(0, 700)), int'($urandom_range(0, 520)),
                             int'($urandom_range(0, 560)));
                pipe_enable = 3'($urandom_range(1, 7));
                fs = 1'b1;
            end
            p  = int'($urandom_range(0, NP - 1));
            gt = m_cen[p] - m_gap[p] / 2;
            gb = gt + m_gap[p];
            h  = m_pos[p] - PW / 2 + int'($urandom_range(0, 60)) - 5;
            case ($urandom_range(0, 3))
                1: v = gb + int'($urandom_range(0, 30)) - 2;
                2: v = gt - int'($urandom_range(0, 30)) + 2;
                default: v = int'($urandom_range(0, 524));
            endcase
            if ($urandom_range(0, 4) == 0) h = int'($urandom_range(0, 799));
            if (h < 0) h = 0;
            if (v < 0) v = 0;
            if (v > 524) v = 524;
            step(h, v, fs, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, k == 250);
        end
        repeat (4) step(0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
